enc_bin2onehot_pipe: RTL and testbench

//  Parametrised, registered binary-to-one-hot/thermometer encoder with valid/ready flow control.

---
 rtl/enc_bin2onehot_pipe.sv | 145 ++++++++++++++
 tb/tb_enc_bin2onehot_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_bin2onehot_pipe.sv
// Registered binary-to-one-hot/thermometer encoder with a two-entry skid buffer,
// out-of-range flagging and a saturating error counter.
module enc_bin2onehot_pipe #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 15,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             clr_cnt
);

   if (OUT_W > (1 << IN_W) || OUT_W < 1) begin : g_param_err
      $error("enc_bin2onehot_pipe: OUT_W must lie in 1..2**IN_W");
   end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   function automatic logic out_of_range(input logic [IN_W-1:0] idx);
      return int'(idx) >= OUT_W;
   endfunction

   function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] idx,
                                                input logic therm);
      logic [OUT_W-1:0] v;
      v = '0;
      if (!out_of_range(idx)) begin
         for (int i = 0; i < OUT_W; i++) begin
            v[i] = therm ? (i <= int'(idx)) : (i == int'(idx));
         end
      end
      return v;
   endfunction

   state_t           state;
   logic             acc;
   logic             pop;
   logic             load_in;
   logic             load_skid;
   logic             skid_to_out;
   logic [OUT_W-1:0] dec_p0;
   logic             err_p0;
   logic [OUT_W-1:0] skid_p1;
   logic             skid_err_p1;

   // Stage p0: decode the request as it is accepted
   always_comb begin
      acc         = in_valid & in_ready;
      pop         = out_valid & out_ready;
      dec_p0      = decode(in, mode);
      err_p0      = out_of_range(in);
      load_in     = acc & ((state == EMPTY) | ((state == ONE) & pop));
      load_skid   = acc & (state == ONE) & ~pop;
      skid_to_out = (state == TWO) & pop;
   end

   // in_ready mirrors the next state so it drops on the same edge the skid fills
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               in_ready <= 1'b1;
               if (acc) begin
                  state     <= ONE;
                  out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (acc && !pop) begin
                  state    <= TWO;
                  in_ready <= 1'b0;
               end else if (!acc && pop) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            TWO: begin
               if (pop) begin
                  state    <= ONE;
                  in_ready <= 1'b1;
               end else begin
                  in_ready <= 1'b0;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

   // Stage p1: output register, cleared on reset so no stale vector is visible
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out     <= '0;
         out_err <= 1'b0;
      end else if (load_in) begin
         out     <= dec_p0;
         out_err <= err_p0;
      end else if (skid_to_out) begin
         out     <= skid_p1;
         out_err <= skid_err_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) begin
         skid_p1     <= dec_p0;
         skid_err_p1 <= err_p0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
      end else if (acc && err_p0 && (err_cnt != {CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Directed bench for enc_bin2onehot_pipe: a negedge monitor keeps a FIFO scoreboard
// and an error-counter model while one initial block drives the test sequence.
module tb_enc_bin2onehot_pipe;

   localparam int IN_W  = 4;
   localparam int OUT_W = 15;
   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in;
   logic             mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out;
   logic             out_err;
   logic [CNT_W-1:0] err_cnt;
   logic             clr_cnt;

   int vectors;
   int miscompares;

   logic [OUT_W:0]   sb[$];
   logic [CNT_W-1:0] exp_cnt;

   enc_bin2onehot_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in       (in),
      .mode     (mode),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (out),
      .out_err  (out_err),
      .err_cnt  (err_cnt),
      .clr_cnt  (clr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {err, vector}; shift-based formulation of the decode
   function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] idx, input logic m);
      int v;
      if (int'(idx) >= OUT_W) return {1'b1, {OUT_W{1'b0}}};
      v = m ? ((1 << (int'(idx) + 1)) - 1) : (1 << int'(idx));
      return {1'b0, v[OUT_W-1:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IN_W-1:0] idx, input logic m);
      logic acc;
      int   t;
      in_valid = 1'b1;
      in       = idx;
      mode     = m;
      t        = 0;
      do begin
         acc = in_ready;
         step();
         t++;
      end while (!acc && t < 50);
      chk("send_accepted", {31'd0, acc}, 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         exp_cnt = '0;
      end else begin
         chk("err_cnt", {30'd0, err_cnt}, {30'd0, exp_cnt});
         if (out_valid && out_ready) begin
            vectors++;
            assert (sb.size() != 0) else begin
               miscompares++;
               $error("FAIL sb_underflow observed=%h expected=empty_pop_none", {out_err, out});
            end
            if (sb.size() != 0) begin
               logic [OUT_W:0] e;
               e = sb.pop_front();
               chk("out_data", {16'd0, out_err, out}, {16'd0, e});
            end
         end
         if (in_valid && in_ready) sb.push_back(model(in, mode));
         if (clr_cnt) exp_cnt = '0;
         else if (in_valid && in_ready && int'(in) >= OUT_W && exp_cnt != {CNT_W{1'b1}})
            exp_cnt = exp_cnt + 1'b1;
      end
   end

   initial begin
      int sent;
      int cyc;
      logic acc;
      vectors     = 0;
      miscompares = 0;
      exp_cnt     = '0;
      rst         = 1'b0;
      in_valid    = 1'b0;
      in          = '0;
      mode        = 1'b0;
      out_ready   = 1'b0;
      clr_cnt     = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out", {17'd0, out}, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
      rst = 1'b1;
      step();
      chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // 1: one-hot stream 0..15
      out_ready = 1'b1;
      send(4'd0, 1'b0);
      chk("latency_valid", {31'd0, out_valid}, 32'd1);
      chk("latency_out", {17'd0, out}, 32'h0001);
      for (int i = 1; i < 16; i++) send(4'(i), 1'b0);
      chk("oor_out", {17'd0, out}, 32'd0);
      chk("oor_err", {31'd0, out_err}, 32'd1);
      idle(3);
      chk("err_cnt_one", {30'd0, err_cnt}, 32'd1);

      // 2: thermometer
      send(4'd3, 1'b1);
      chk("therm3", {17'd0, out}, 32'h000F);
      send(4'd14, 1'b1);
      chk("therm14", {17'd0, out}, 32'h7FFF);
      send(4'd0, 1'b1);
      chk("therm0", {17'd0, out}, 32'h0001);
      idle(3);

      // 3: backpressure fills skid
      out_ready = 1'b0;
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      chk("ready_low_two", {31'd0, in_ready}, 32'd0);
      in = 4'd3;
      repeat (3) step();
      chk("ready_held_low", {31'd0, in_ready}, 32'd0);
      chk("stall_out_stable", {17'd0, out}, 32'h0002);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      send(4'd3, 1'b0);
      idle(4);
      chk("sb_empty_t3", sb.size(), 32'd0);

      // 4: random stream with out_ready toggling
      in_valid = 1'b1;
      in       = 4'($urandom_range(0, 15));
      mode     = 1'($urandom_range(0, 1));
      sent     = 0;
      cyc      = 0;
      while (sent < 40 && cyc < 400) begin
         out_ready = (cyc % 2 == 0);
         acc = in_ready;
         step();
         cyc++;
         if (acc) begin
            sent++;
            in   = 4'($urandom_range(0, 15));
            mode = 1'($urandom_range(0, 1));
         end
      end
      chk("t4_all_sent", sent, 32'd40);
      out_ready = 1'b1;
      idle(6);
      chk("sb_empty_t4", sb.size(), 32'd0);

      // 5: counter saturation and clear priority
      clr_cnt = 1'b1;
      step();
      clr_cnt = 1'b0;
      chk("cnt_cleared", {30'd0, err_cnt}, 32'd0);
      for (int i = 0; i < 5; i++) send(4'd15, 1'b0);
      idle(2);
      chk("cnt_saturated", {30'd0, err_cnt}, 32'd3);
      in_valid = 1'b1;
      in       = 4'd15;
      clr_cnt  = 1'b1;
      step();
      clr_cnt  = 1'b0;
      in_valid = 1'b0;
      chk("cnt_clr_priority", {30'd0, err_cnt}, 32'd0);
      idle(3);

      // 6: reset while in TWO
      out_ready = 1'b0;
      send(4'd2, 1'b0);
      send(4'd9, 1'b1);
      in_valid = 1'b0;
      chk("t6_ready_low", {31'd0, in_ready}, 32'd0);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_out", {17'd0, out}, 32'd0);
      chk("t6_rst_err", {31'd0, out_err}, 32'd0);
      chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      chk("t6_ready_back", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      send(4'd7, 1'b1);
      chk("t6_first_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_first_out", {17'd0, out}, 32'h00FF);
      idle(3);
      chk("sb_empty_end", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
